spi_slave: RTL and testbench

SPI-mode-0 slave front end for the single-port RAM.
- Deserialises MOSI frames into 10-bit words: 2-bit command plus 8-bit address/data.
- Presents each completed word to the RAM as rx_data with a one-cycle rx_valid pulse.
- Serialises the RAM's 8-bit read data back out on MISO.
- Sits directly upstream of the RAM: rx_data/rx_valid drive the RAM's din/rx_valid, and the RAM's dout/tx_valid drive tx_data/tx_valid here.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_tx_shifter.sv | 54 +++++
 rtl/spi_slave.sv | 144 ++++++++++++++
 tb/tb_spi_slave.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI slave front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int c_FRAME_W = 10;
    localparam int c_TX_W    = 8;

    localparam logic [1:0] c_CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] c_CMD_WR_DATA = 2'b01;
    localparam logic [1:0] c_CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] c_CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_tx_shifter.sv
// ============================================================================
// Module      : spi_tx_shifter
// Description : Parallel-to-serial MISO shifter, MSB first, idles at 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int TX_W = c_TX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [TX_W-1:0] din,
    output logic            miso,
    output logic            done
);

    localparam int c_REM_W = $clog2(TX_W);

    logic [TX_W-1:0]    r_sh;
    logic [c_REM_W-1:0] r_rem;

    // r_rem counts bits still waiting behind the one currently on miso
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_rem <= '0;
            miso  <= 1'b0;
        end else if (clr) begin
            r_sh  <= '0;
            r_rem <= '0;
            miso  <= 1'b0;
        end else if (load) begin
            miso  <= din[TX_W-1];
            r_sh  <= {din[TX_W-2:0], 1'b0};
            r_rem <= c_REM_W'(TX_W - 1);
        end else if (r_rem != '0) begin
            miso  <= r_sh[TX_W-1];
            r_sh  <= {r_sh[TX_W-2:0], 1'b0};
            r_rem <= r_rem - 1'b1;
        end else begin
            miso  <= 1'b0;
        end
    end

    assign done = (r_rem == '0);

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-0 slave: frame receiver, command FSM and MISO driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W = c_FRAME_W,
    parameter int TX_W    = c_TX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [TX_W-1:0]    tx_data,
    input  logic               tx_valid
);

    localparam int                 c_CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(FRAME_W - 1);

    spi_state_t         r_state;
    spi_state_t         w_next;
    logic [FRAME_W-1:0] r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic               r_rd_addr_seen;
    logic               r_tx_loaded;
    logic               w_capture;
    logic               w_last;
    logic               w_abort;
    logic               w_tx_load;
    logic               w_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_last    = 1'b0;
        w_abort   = 1'b0;
        w_tx_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (!SS_n) begin
                    w_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    w_capture = 1'b1;
                    if (MOSI == c_CMD_WR_ADDR[1]) begin
                        w_next = WRITE;
                    end else if (r_rd_addr_seen) begin
                        w_next = READ_DATA;
                    end else begin
                        w_next = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    // Once the frame is complete, further MOSI bits are ignored
                    w_capture = !r_done;
                    w_last    = !r_done && (r_cnt == c_LAST_CNT);
                    w_tx_load = (r_state == READ_DATA) && r_done && tx_valid
                                && !r_tx_loaded && w_tx_done;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift        <= '0;
            r_cnt          <= '0;
            r_done         <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_tx_loaded    <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= w_last;
            if (w_abort) begin
                r_cnt       <= '0;
                r_done      <= 1'b0;
                r_tx_loaded <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_shift <= {r_shift[FRAME_W-2:0], MOSI};
                    r_cnt   <= r_cnt + 1'b1;
                end
                if (w_last) begin
                    rx_data <= {r_shift[FRAME_W-2:0], MOSI};
                    r_done  <= 1'b1;
                    if (r_state == READ_ADD) begin
                        r_rd_addr_seen <= 1'b1;
                    end else if (r_state == READ_DATA) begin
                        r_rd_addr_seen <= 1'b0;
                    end
                end
                if (w_tx_load) begin
                    r_tx_loaded <= 1'b1;
                end
            end
        end
    end

    spi_tx_shifter #(
        .TX_W (TX_W)
    ) u_tx_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_abort),
        .load  (w_tx_load),
        .din   (tx_data),
        .miso  (MISO),
        .done  (w_tx_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module      : tb_spi_slave
// Description : Scoreboard bench for spi_slave with a frame-level SPI/RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    typedef struct packed {
        logic       v;
        logic       m;
        logic [9:0] d;
    } exp_t;

    exp_t       eq[$];
    logic [9:0] rxq[$];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         rd_seen     = 1'b0;
    logic [9:0] model_rx    = '0;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One SPI clock: drive inputs for the coming edge and queue what must follow it
    task automatic cyc(input logic ss, input logic mosi, input logic tv,
                       input logic ev, input logic em);
        @(negedge clk);
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = tv;
        eq.push_back('{ev, em, model_rx});
    endtask

    // One SS_n-low window: E0, nbits frame bits, extra held cycles, then SS_n high.
    // The RAM answers a read-data frame with tx_valid from E12 onward.
    task automatic frame(input logic [9:0] w, input int nbits, input int extra,
                         input int rst_at, input logic [7:0] d);
        bit   rd;
        logic em;
        rd      = (nbits == 10) && w[9] && rd_seen;
        tx_data = d;
        cyc(1'b0, rb(), rd ? 1'b0 : rb(), 1'b0, 1'b0);
        for (int k = 1; k <= nbits; k++) begin
            if (k == 10) begin
                model_rx = w;
                rxq.push_back(w);
            end
            cyc(1'b0, w[10-k], rd ? 1'b0 : rb(), k == 10, 1'b0);
        end
        for (int k = 11; nbits == 10 && k <= 10 + extra; k++) begin
            em = (rd && k >= 12 && k <= 19) ? d[19-k] : 1'b0;
            cyc(1'b0, rb(), rd ? (k >= 12) : rb(), 1'b0, em);
            if (k == rst_at) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("rst_mid_miso", {31'd0, MISO}, 32'd0);
                check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
                check("rst_mid_rx_data", {22'd0, rx_data}, 32'd0);
                rd_seen  = 1'b0;
                model_rx = '0;
                @(negedge clk);
                rst_n    = 1'b1;
                SS_n     = 1'b1;
                tx_valid = 1'b0;
                eq.push_back('{1'b0, 1'b0, 10'h000});
                return;
            end
        end
        cyc(1'b1, rb(), 1'b0, 1'b0, 1'b0);
        if (nbits == 10 && w[9]) begin
            rd_seen = !rd_seen;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                check("rx_valid", {31'd0, rx_valid}, {31'd0, e.v});
                check("miso", {31'd0, MISO}, {31'd0, e.m});
                check("rx_data_hold", {22'd0, rx_data}, {22'd0, e.d});
            end
            if (rx_valid === 1'b1) begin
                if (rxq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_rx_valid: rx_data %0h, expected no pulse", rx_data);
                end else begin
                    check("rx_word", {22'd0, rx_data}, {22'd0, rxq.pop_front()});
                end
            end
        end
    end

    initial begin
        int nb;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {22'd0, rx_data}, 32'd0);
        rst_n = 1'b1;

        // write address, read address then read data returning 0xA5
        frame(10'h03C, 10, 4, 0, 8'h00);
        frame(10'h215, 10, 2, 0, 8'h00);
        frame({2'b11, 8'($urandom)}, 10, 12, 0, 8'hA5);

        // read-address flag toggles: third bit9=1 frame is a READ_ADD again
        frame({2'b10, 8'($urandom)}, 10, 2, 0, 8'($urandom));
        frame({2'b11, 8'($urandom)}, 10, 12, 0, 8'($urandom));
        frame({2'b11, 8'($urandom)}, 10, 12, 0, 8'($urandom));
        frame({2'b11, 8'($urandom)}, 10, 12, 0, 8'($urandom));

        // abort after 5 bits, then a full frame
        frame(10'h0F0, 5, 0, 0, 8'h00);
        frame(10'h1A5, 10, 2, 0, 8'h00);

        // async reset while MISO carries bit 3, then a read frame must be READ_ADD
        frame({2'b10, 8'($urandom)}, 10, 2, 0, 8'($urandom));
        frame({2'b11, 8'($urandom)}, 10, 12, 16, 8'h5A);
        frame({2'b11, 8'($urandom)}, 10, 12, 0, 8'($urandom));

        // sticky tx_valid: eight bits only, no reload
        frame({2'b11, 8'($urandom)}, 10, 30, 0, 8'($urandom));

        repeat (40) begin
            nb = rb() ? 10 : $urandom_range(1, 9);
            frame(10'($urandom), nb, (nb == 10) ? $urandom_range(0, 25) : 0, 0, 8'($urandom));
            repeat ($urandom_range(0, 2)) cyc(1'b1, rb(), rb(), 1'b0, 1'b0);
        end

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("expect_queue_drained", eq.size(), 32'd0);
        check("rx_queue_drained", rxq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
